// File: rtl/hidden_neuron_mac_if.sv
// hidden_neuron_mac_if: start/ready/valid request bus with operands and result of one serial MAC neuron.
//   master: drives start_i, x_i, w_i, bias_i; receives ready_o, valid_o, neuron_o, sat_o
//   slave : the neuron side of the same bus
interface hidden_neuron_mac_if #(
    parameter int N_INPUTS  = 4,
    parameter int W_WIDTH   = 8,
    parameter int OUT_WIDTH = 10
);
    logic                         start_i;
    logic [N_INPUTS-1:0]          x_i;
    logic [N_INPUTS*W_WIDTH-1:0]  w_i;
    logic signed [W_WIDTH-1:0]    bias_i;
    logic                         ready_o;
    logic                         valid_o;
    logic [OUT_WIDTH-1:0]         neuron_o;
    logic                         sat_o;
    modport master (output start_i, x_i, w_i, bias_i, input ready_o, valid_o, neuron_o, sat_o);
    modport slave  (input start_i, x_i, w_i, bias_i, output ready_o, valid_o, neuron_o, sat_o);
endinterface

// File: rtl/hidden_neuron_mac.sv
// hidden_neuron_mac: serial MAC neuron, y = act(bias + sum x[k]*w[k]), one input per cycle.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   bus   : hidden_neuron_mac_if.slave (start/ready/valid handshake, operands, saturated result)
module hidden_neuron_mac #(
    parameter int N_INPUTS  = 4,
    parameter int W_WIDTH   = 8,
    parameter int OUT_WIDTH = 10,
    parameter bit RELU_EN   = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    hidden_neuron_mac_if.slave bus
);
    localparam int ACC_W = W_WIDTH + $clog2(N_INPUTS + 1) + 1;
    localparam int KW    = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
    // compare width is wider than both the accumulator and the output so every limit fits as a positive value
    localparam int CW    = (ACC_W > OUT_WIDTH ? ACC_W : OUT_WIDTH) + 1;
    localparam logic signed [CW-1:0] UMAX = (CW'(1) << OUT_WIDTH) - CW'(1);
    localparam logic signed [CW-1:0] SMAX = (CW'(1) << (OUT_WIDTH - 1)) - CW'(1);
    localparam logic signed [CW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                     state_q;
    logic [KW-1:0]              k_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic [N_INPUTS-1:0]        x_q;
    logic signed [W_WIDTH-1:0]  w_q [N_INPUTS];
    logic                       ready_q, valid_q, sat_q;
    logic [OUT_WIDTH-1:0]       neuron_q;
    logic signed [CW-1:0]       acc_ext;
    logic                       hi, lo, sat_d;
    logic [OUT_WIDTH-1:0]       neuron_d;

    always_comb begin
        acc_ext  = CW'(acc_q);
        hi       = RELU_EN ? acc_ext > UMAX : acc_ext > SMAX;
        // with ReLU a negative sum is clipped to zero, which is not reported as saturation
        lo       = !RELU_EN && acc_ext < SMIN;
        sat_d    = hi | lo;
        neuron_d = (RELU_EN && acc_ext < 0) ? '0 :
                   hi ? (RELU_EN ? UMAX[OUT_WIDTH-1:0] : SMAX[OUT_WIDTH-1:0]) :
                   lo ? SMIN[OUT_WIDTH-1:0] : acc_ext[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            neuron_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start_i) begin
                        x_q     <= bus.x_i;
                        for (int i = 0; i < N_INPUTS; i++) w_q[i] <= bus.w_i[i*W_WIDTH +: W_WIDTH];
                        acc_q   <= ACC_W'(bus.bias_i);
                        k_q     <= '0;
                        ready_q <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (x_q[k_q]) acc_q <= acc_q + ACC_W'(w_q[k_q]);
                    k_q <= k_q + 1'b1;
                    if (k_q == KW'(N_INPUTS - 1)) state_q <= DONE;
                end
                default: begin
                    neuron_q <= neuron_d;
                    sat_q    <= sat_d;
                    valid_q  <= 1'b1;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.neuron_o = neuron_q;
    assign bus.sat_o    = sat_q;
endmodule

// File: tb/tb_hidden_neuron_mac.sv
// tb_hidden_neuron_mac: three neuron variants (ReLU 10b, ReLU 8b, linear 10b) driven in lockstep, checked against a scoreboard.
module tb_hidden_neuron_mac;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  x = '0;
    logic [31:0] w = '0;
    logic [7:0]  bias = '0;

    always #5 clk = ~clk;

    hidden_neuron_mac_if #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(10)) i0 ();
    hidden_neuron_mac_if #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(8))  i1 ();
    hidden_neuron_mac_if #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(10)) i2 ();

    assign i0.start_i = start; assign i0.x_i = x; assign i0.w_i = w; assign i0.bias_i = bias;
    assign i1.start_i = start; assign i1.x_i = x; assign i1.w_i = w; assign i1.bias_i = bias;
    assign i2.start_i = start; assign i2.x_i = x; assign i2.w_i = w; assign i2.bias_i = bias;

    hidden_neuron_mac #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(10), .RELU_EN(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus(i0.slave));
    hidden_neuron_mac #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(8),  .RELU_EN(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(i1.slave));
    hidden_neuron_mac #(.N_INPUTS(4), .W_WIDTH(8), .OUT_WIDTH(10), .RELU_EN(1'b0)) dut2 (.clk_i(clk), .rst_i(rst), .bus(i2.slave));

    typedef struct {
        logic [3:0]  x;
        logic [31:0] w;
        logic [7:0]  b;
        logic [9:0]  n0;
        logic        s0;
        logic [7:0]  n1;
        logic        s1;
        logic [9:0]  n2;
        logic        s2;
    } vec_t;

    vec_t v [8];
    vec_t sbq [$];
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   cnt = 0;
    logic exp_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else passed++;
    endtask

    // cycle model: an accepted start keeps the neuron busy for N_INPUTS+1 edges, then one valid cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt = 0;
            exp_valid = 1'b0;
            sbq.delete();
        end else begin
            exp_valid = 1'b0;
            if (cnt == 0) begin
                if (start) cnt = 5;
            end else begin
                cnt--;
                if (cnt == 0) exp_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("hs0", {30'd0, i0.ready_o, i0.valid_o}, {30'd0, cnt == 0, exp_valid});
            chk("hs1", {30'd0, i1.ready_o, i1.valid_o}, {30'd0, cnt == 0, exp_valid});
            chk("hs2", {30'd0, i2.ready_o, i2.valid_o}, {30'd0, cnt == 0, exp_valid});
            if (exp_valid) begin
                if (sbq.size() == 0) begin
                    total++; failed++;
                    $display("FAIL sb_underflow: got valid expected no pending result at %0t", $time);
                end else begin
                    vec_t e;
                    e = sbq.pop_front();
                    chk("res0", {21'd0, i0.sat_o, i0.neuron_o}, {21'd0, e.s0, e.n0});
                    chk("res1", {23'd0, i1.sat_o, i1.neuron_o}, {23'd0, e.s1, e.n1});
                    chk("res2", {21'd0, i2.sat_o, i2.neuron_o}, {21'd0, e.s2, e.n2});
                end
            end
        end
    end

    task automatic drive(input vec_t t);
        x = t.x; w = t.w; bias = t.b;
        sbq.push_back(t);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && cnt != 0; i++) @(negedge clk);
        if (cnt != 0) begin
            total++; failed++;
            $display("FAIL idle_timeout: got busy expected idle at %0t", $time);
        end
    endtask

    task automatic run_op(input vec_t t);
        start = 1'b1;
        drive(t);
        @(negedge clk);
        start = 1'b0;
        x = 4'($urandom); w = $urandom; bias = 8'($urandom);
        wait_idle();
    endtask

    task automatic chk_reset();
        chk("rst0", {20'd0, i0.ready_o, i0.valid_o, i0.sat_o, i0.neuron_o}, {20'd0, 3'b100, 10'd0});
        chk("rst1", {22'd0, i1.ready_o, i1.valid_o, i1.sat_o, i1.neuron_o}, {22'd0, 3'b100, 8'd0});
        chk("rst2", {20'd0, i2.ready_o, i2.valid_o, i2.sat_o, i2.neuron_o}, {20'd0, 3'b100, 10'd0});
    endtask

    initial begin
        v[0] = '{4'b1111, 32'h40404040, 8'h00, 10'd256,  1'b0, 8'd255, 1'b1, 10'd256,  1'b0};
        v[1] = '{4'b0001, 32'h40404080, 8'h00, 10'd0,    1'b0, 8'd0,   1'b0, 10'h380,  1'b0};
        v[2] = '{4'b1111, 32'h7F7F7F7F, 8'h7F, 10'd635,  1'b0, 8'hFF,  1'b1, 10'h1FF,  1'b1};
        v[3] = '{4'b0011, 32'h7F7F2080, 8'hF0, 10'd0,    1'b0, 8'd0,   1'b0, 10'h390,  1'b0};
        v[4] = '{4'b0000, 32'h7F7F7F7F, 8'h30, 10'd48,   1'b0, 8'd48,  1'b0, 10'd48,   1'b0};
        v[5] = '{4'b1111, 32'h80808080, 8'h80, 10'd0,    1'b0, 8'd0,   1'b0, 10'h200,  1'b1};
        v[6] = '{4'b1010, 32'h7F012210, 8'h05, 10'd166,  1'b0, 8'd166, 1'b0, 10'd166,  1'b0};
        v[7] = '{4'b0110, 32'h7F7F7F7F, 8'h7F, 10'd381,  1'b0, 8'd255, 1'b1, 10'd381,  1'b0};
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_op(v[i]);
        // start held high: the second request is taken only when ready returns, with operands present then
        start = 1'b1;
        drive(v[0]);
        repeat (3) @(negedge clk);
        drive(v[6]);
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_idle();
        // reset in the middle of an operation aborts it without a valid pulse
        start = 1'b1;
        drive(v[2]);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(v[0]);
        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
